mat_loader: RTL

MAT_LOADER -- requirements
Module: mat_loader

---
 rtl/mat_loader.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/mat_loader.sv
// rtl/mat_loader.sv - streams host words into op/A/B memory lines, commits the header, then polls for completion
module mat_loader #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned BANDWIDTH   = 4,
  parameter int unsigned ADDR_WIDTH  = 16,
  parameter int unsigned OP_ADDR     = 0,
  parameter int unsigned SCALAR_ADDR = 1,
  parameter int unsigned DATAA_ADDR  = 32'h0100,
  parameter int unsigned DATAB_ADDR  = 32'h4100
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [DATA_WIDTH-1:0]           in_data,
  output logic                            wr_en,
  output logic [1:0]                      wr_sel,
  output logic [ADDR_WIDTH-1:0]           wr_addr,
  output logic [DATA_WIDTH*BANDWIDTH-1:0] wr_data,
  output logic                            rd_en,
  output logic [ADDR_WIDTH-1:0]           rd_addr,
  input  logic [DATA_WIDTH*BANDWIDTH-1:0] rd_data,
  output logic                            busy,
  output logic                            done,
  output logic                            err
);

  localparam int unsigned LINE_W = DATA_WIDTH * BANDWIDTH;
  localparam int unsigned LANE_W = (BANDWIDTH > 1) ? $clog2(BANDWIDTH) : 1;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(BANDWIDTH - 1);
  localparam logic [3:0] OP_MAT_ADD = 4'd1;

  typedef enum logic [2:0] {
    IDLE, HDR, SCALAR, LOAD_A, LOAD_B, COMMIT, POLL
  } state_t;

  state_t                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   hdr_q, hdr_d;
  logic [15:0]             lines_q, lines_d;
  logic [15:0]             line_idx_q, line_idx_d;
  logic [LANE_W-1:0]       lane_q, lane_d;
  logic [DATA_WIDTH-1:0]   lbuf_q [BANDWIDTH];
  logic [DATA_WIDTH-1:0]   lbuf_d [BANDWIDTH];
  logic                    wr_en_q, wr_en_d;
  logic [1:0]              wr_sel_q, wr_sel_d;
  logic [ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
  logic [LINE_W-1:0]       wr_data_q, wr_data_d;
  logic                    rd_en_q, rd_en_d;
  logic [ADDR_WIDTH-1:0]   rd_addr_q, rd_addr_d;
  logic                    rd_pend_q, rd_pend_d;
  logic                    zero_seen_q, zero_seen_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;

  logic [3:0]              hdr_op;
  logic [15:0]             hdr_n;
  logic                    hdr_bad;
  logic [LINE_W-1:0]       full_line;
  logic                    rd_data_unused;

  // Only the op field of the polled line carries status.
  assign rd_data_unused = ^rd_data[LINE_W-1:4];

  always_comb begin
    hdr_op  = in_data[3:0];
    hdr_n   = 16'(in_data[15:8]) * 16'(in_data[23:16]);
    hdr_bad = (hdr_n == 16'd0) || ((hdr_n % 16'(BANDWIDTH)) != 16'd0) ||
              (hdr_op == 4'd0) || (hdr_op > 4'd5);
  end

  // The completing word goes straight into the outgoing line so no bubble is needed.
  always_comb begin
    full_line = '0;
    for (int unsigned k = 0; k < BANDWIDTH; k++) begin
      full_line[k*DATA_WIDTH +: DATA_WIDTH] = (k == BANDWIDTH - 1) ? in_data : lbuf_q[k];
    end
  end

  always_comb begin
    state_d     = state_q;
    hdr_d       = hdr_q;
    lines_d     = lines_q;
    line_idx_d  = line_idx_q;
    lane_d      = lane_q;
    lbuf_d      = lbuf_q;
    wr_en_d     = 1'b0;
    wr_sel_d    = wr_sel_q;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    rd_en_d     = 1'b0;
    rd_addr_d   = rd_addr_q;
    rd_pend_d   = rd_en_q;
    zero_seen_d = 1'b0;
    busy_d      = busy_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    in_ready    = 1'b0;

    case (state_q)
      IDLE: state_d = HDR;

      HDR: begin
        in_ready = 1'b1;
        if (in_valid) begin
          hdr_d      = in_data;
          lines_d    = hdr_n / 16'(BANDWIDTH);
          line_idx_d = 16'd0;
          lane_d     = '0;
          if (hdr_bad) begin
            err_d = 1'b1;
          end else begin
            busy_d  = 1'b1;
            state_d = (hdr_op == OP_MAT_ADD) ? LOAD_A : SCALAR;
          end
        end
      end

      SCALAR: begin
        in_ready = 1'b1;
        if (in_valid) begin
          wr_en_d                     = 1'b1;
          wr_sel_d                    = 2'd0;
          wr_addr_d                   = ADDR_WIDTH'(SCALAR_ADDR);
          wr_data_d                   = '0;
          wr_data_d[DATA_WIDTH-1:0]   = in_data;
          state_d                     = LOAD_A;
        end
      end

      LOAD_A, LOAD_B: begin
        in_ready = 1'b1;
        if (in_valid) begin
          lbuf_d[lane_q] = in_data;
          if (lane_q == LAST_LANE) begin
            lane_d    = '0;
            wr_en_d   = 1'b1;
            wr_sel_d  = (state_q == LOAD_A) ? 2'd1 : 2'd2;
            wr_addr_d = ((state_q == LOAD_A) ? ADDR_WIDTH'(DATAA_ADDR) : ADDR_WIDTH'(DATAB_ADDR))
                        + ADDR_WIDTH'(line_idx_q);
            wr_data_d = full_line;
            if (line_idx_q == lines_q - 16'd1) begin
              line_idx_d = 16'd0;
              state_d    = (state_q == LOAD_A && hdr_q[3:0] == OP_MAT_ADD) ? LOAD_B : COMMIT;
            end else begin
              line_idx_d = line_idx_q + 16'd1;
            end
          end else begin
            lane_d = lane_q + LANE_W'(1);
          end
        end
      end

      COMMIT: begin
        // Let the final data line go out before the header write that starts the job.
        if (!wr_en_q) begin
          wr_en_d                   = 1'b1;
          wr_sel_d                  = 2'd0;
          wr_addr_d                 = ADDR_WIDTH'(OP_ADDR);
          wr_data_d                 = '0;
          wr_data_d[DATA_WIDTH-1:0] = hdr_q;
          state_d                   = POLL;
        end
      end

      POLL: begin
        if (zero_seen_q) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = HDR;
        end else begin
          rd_en_d     = 1'b1;
          rd_addr_d   = ADDR_WIDTH'(OP_ADDR);
          zero_seen_d = rd_pend_q && (rd_data[3:0] == 4'd0);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      hdr_q       <= '0;
      lines_q     <= '0;
      line_idx_q  <= '0;
      lane_q      <= '0;
      for (int unsigned k = 0; k < BANDWIDTH; k++) lbuf_q[k] <= '0;
      wr_en_q     <= 1'b0;
      wr_sel_q    <= '0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      rd_en_q     <= 1'b0;
      rd_addr_q   <= '0;
      rd_pend_q   <= 1'b0;
      zero_seen_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      hdr_q       <= hdr_d;
      lines_q     <= lines_d;
      line_idx_q  <= line_idx_d;
      lane_q      <= lane_d;
      lbuf_q      <= lbuf_d;
      wr_en_q     <= wr_en_d;
      wr_sel_q    <= wr_sel_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      rd_en_q     <= rd_en_d;
      rd_addr_q   <= rd_addr_d;
      rd_pend_q   <= rd_pend_d;
      zero_seen_q <= zero_seen_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_sel  = wr_sel_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign rd_en   = rd_en_q;
  assign rd_addr = rd_addr_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;

endmodule
